// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Handshake bundle between the ID/EX operand latch (master) and the
// sequential ALU (slave).
//   in_valid / in_ready   operand-side handshake
//   in1, in2, alu_op      operands and operation code
//   out_valid / out_ready result-side handshake
//   out, zflag, illegal   registered result, zero flag, illegal-op flag
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zflag;
    logic             illegal;

    modport master (
        output in_valid, in1, in2, alu_op, out_ready,
        input  in_ready, out_valid, out, zflag, illegal
    );

    modport slave (
        input  in_valid, in1, in2, alu_op, out_ready,
        output in_ready, out_valid, out, zflag, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered RV64I ALU. Logic/add/sub/compare ops complete on the accept edge;
// MUL (shift-add) and DIVU/REMU (restoring division) iterate one bit per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave: in_valid/in_ready/in1/in2/alu_op on the input
//          side, out_valid/out_ready/out/zflag/illegal on the output side
// Parameters:
//   WIDTH  operand/result width (>= 8)
//   CNT_W  iteration counter width, $clog2(WIDTH)+1
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;       // MUL: shifted multiplicand; DIV: dividend in, quotient out
    logic [WIDTH-1:0] b_q, b_d;       // MUL: shifted multiplier;   DIV: divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL: partial product;      DIV: partial remainder
    logic [WIDTH-1:0] out_q, out_d;
    logic             zflag_q, zflag_d;
    logic             illegal_q, illegal_d;
    logic             load_s;

    logic [WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] iter_result_s;

    // Opcode decode: true for every operation this ALU implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU,
            OP_NOR, OP_MUL, OP_DIVU, OP_REMU: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Result of every op that finishes on the accept edge. DIVU/REMU only reach
    // here with a zero divisor; MUL never does; illegal ops land on default.
    function automatic logic [WIDTH-1:0] single_result(input logic [3:0]       op,
                                                       input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  r = ~(a | b);
            OP_DIVU: r = {WIDTH{1'b1}};
            OP_REMU: r = a;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        if (b_q[0]) begin
            mul_acc_s = acc_q + a_q;
        end else begin
            mul_acc_s = acc_q;
        end
        // Bring the next dividend bit into the partial remainder, then trial-subtract.
        div_shift_s = {acc_q, a_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        if (div_diff_s[WIDTH]) begin
            div_rem_s = div_shift_s[WIDTH-1:0];
        end else begin
            div_rem_s = div_diff_s[WIDTH-1:0];
        end
        div_quo_s = {a_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
        case (op_q)
            OP_MUL:  iter_result_s = mul_acc_s;
            OP_DIVU: iter_result_s = div_quo_s;
            default: iter_result_s = div_rem_s;
        endcase
    end

    // Next-state, datapath and result-register control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        out_d     = out_q;
        illegal_d = illegal_q;
        load_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.alu_op;
                    a_d   = bus.in1;
                    b_d   = bus.in2;
                    acc_d = {WIDTH{1'b0}};
                    if ((bus.alu_op == OP_MUL) ||
                        (((bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU)) &&
                         (bus.in2 != {WIDTH{1'b0}}))) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        state_d   = S_DONE;
                        out_d     = single_result(bus.alu_op, bus.in1, bus.in2);
                        illegal_d = ~op_is_legal(bus.alu_op);
                        load_s    = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_s;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_rem_s;
                    a_d   = div_quo_s;
                end
                // Final iteration: publish the value this edge would have stored.
                if (cnt_q == CNT_W'(1)) begin
                    out_d     = iter_result_s;
                    illegal_d = 1'b0;
                    load_s    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // zflag tracks the value being loaded, so it changes only with out.
        if (load_s) begin
            zflag_d = (out_d == {WIDTH{1'b0}});
        end else begin
            zflag_d = zflag_q;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 4'b0000;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            out_q     <= {WIDTH{1'b0}};
            zflag_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            zflag_q   <= zflag_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.zflag     = zflag_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=64). The driver pushes the expected
// result of each accepted op, computed with plain arithmetic, into a queue;
// a monitor pops on every new result and checks value, flags, arrival time
// and that the result stays stable while held.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int W = 64;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        ill;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_low = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: result from the ALU rules; iterative ops land W edges after accept.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int acc_cyc);
        exp_t e;
        int   lat;
        e.ill = 1'b0;
        lat   = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1000: e.res = (a < b) ? 64'd1 : 64'd0;
            4'b1100: e.res = ~(a | b);
            4'b0011: begin e.res = a * b; lat = W; end
            4'b0100: begin
                if (b == 64'd0) e.res = 64'hFFFF_FFFF_FFFF_FFFF;
                else begin e.res = a / b; lat = W; end
            end
            4'b0101: begin
                if (b == 64'd0) e.res = a;
                else begin e.res = a % b; lat = W; end
            end
            default: begin e.res = 64'd0; e.ill = 1'b1; end
        endcase
        e.z   = (e.res == 64'd0);
        e.due = acc_cyc + lat;
        return e;
    endfunction

    // Drive one op; called and returns at a falling edge. Junk is shown while busy.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 500) begin
            bus.in_valid = 1'b1;
            bus.alu_op   = 4'($urandom_range(0, 15));
            bus.in1      = {$urandom(), $urandom()};
            bus.in2      = {$urandom(), $urandom()};
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
            bus.in_valid = 1'b0;
        end else begin
            bus.in_valid = 1'b1;
            bus.alu_op   = op;
            bus.in1      = a;
            bus.in2      = b;
            exp_q.push_back(model(op, a, b, cyc + 1));
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'($urandom_range(0, 300));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Consumer: random acceptance, or forced stall for the backpressure test.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop on each new result, then check it every cycle it is held.
    initial begin
        exp_t cur;
        bit   have_cur = 1'b0;
        logic prev_v   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_v   = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (bus.out_valid === 1'b1 && prev_v !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: out_valid=1 out=0x%016h, expected no result", bus.out);
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("latency", 64'(cyc), 64'(cur.due));
                    end
                end
                if (bus.out_valid === 1'b1 && have_cur) begin
                    check("out", bus.out, cur.res);
                    check("zflag", 64'(bus.zflag), 64'(cur.z));
                    check("illegal", 64'(bus.illegal), 64'(cur.ill));
                    check("in_ready_done", 64'(bus.in_ready), 64'd0);
                end
                prev_v = bus.out_valid;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legal_ops [10];
        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                      4'b1000, 4'b1100, 4'b0011, 4'b0100, 4'b0101};
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in1      = 64'd0;
        bus.in2      = 64'd0;
        bus.alu_op   = 4'b0000;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out", bus.out, 64'd0);
        check("rst_zflag", 64'(bus.zflag), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        issue(4'b0110, 64'd5, 64'd7);
        issue(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        issue(4'b0011, 64'h0000_0001_0000_0001, 64'd3);
        issue(4'b0100, 64'd100, 64'd7);
        issue(4'b0101, 64'd100, 64'd7);
        issue(4'b0100, 64'd42, 64'd0);
        issue(4'b0101, 64'd42, 64'd0);
        issue(4'b1111, 64'd42, 64'd9);
        issue(4'b1001, 64'd1, 64'd2);
        issue(4'b0100, 64'd3, 64'd200);
        drain();

        // Randomized ops, mostly legal.
        for (int i = 0; i < 120; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            else                           op = legal_ops[$urandom_range(0, 9)];
            issue(op, rand_operand(), rand_operand());
        end
        drain();

        // Backpressure: result must hold while out_ready stays low.
        hold_low = 1'b1;
        @(negedge clk);
        issue(4'b0010, 64'd3, 64'd4);
        repeat (10) @(negedge clk);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out", bus.out, 64'd7);
        hold_low = 1'b0;
        drain();

        // Abort: reset while a multiply is iterating produces no result.
        issue(4'b0011, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out", bus.out, 64'd0);
        check("abort_zflag", 64'(bus.zflag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_no_result", 64'(bus.out_valid), 64'd0);

        // Recovery after abort.
        issue(4'b1100, 64'd0, 64'd0);
        issue(4'b0011, 64'd12345, 64'd678);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
